// File: rtl/keccak_pkg.sv
// Shared Keccak constants, squeeze FSM encoding and a rate-limited lane selector.
package keccak_pkg;

    localparam int STATE_W       = 1600;
    localparam int LANE_W        = 64;
    localparam int NUM_LANES     = 25;
    localparam int RATE128_LANES = 21;
    localparam int RATE256_LANES = 17;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PERM = 3'd1,
        STREAM    = 3'd2,
        REQ       = 3'd3,
        DONE      = 3'd4
    } sq_state_e;

    // Lanes at or above n_lanes belong to the capacity and always read as zero.
    function automatic logic [LANE_W-1:0] get_lane(input logic [STATE_W-1:0] s,
                                                   input int idx,
                                                   input int n_lanes);
        logic [LANE_W-1:0] lane;
        lane = {LANE_W{1'b0}};
        for (int i = 0; i < NUM_LANES; i++) begin
            lane = ((i < n_lanes) && (i == idx)) ? s[LANE_W*i +: LANE_W] : lane;
        end
        return lane;
    endfunction

endpackage

// File: rtl/shake_squeeze_if.sv
// Request, permutation and output-stream signals of the squeeze stage.
interface shake_squeeze_if #(parameter int LEN_W = 16);
    import keccak_pkg::*;

    logic                start;
    logic [LEN_W-1:0]    out_len;
    logic [STATE_W-1:0]  perm_state_in;
    logic                perm_done;
    logic                perm_req;
    logic [STATE_W-1:0]  perm_state_out;
    logic [LANE_W-1:0]   dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;
    logic                busy;
    logic                done;

    modport slave (
        input  start, out_len, perm_state_in, perm_done, dout_ready,
        output perm_req, perm_state_out, dout, dout_valid, dout_last, busy, done
    );

    modport master (
        output start, out_len, perm_state_in, perm_done, dout_ready,
        input  perm_req, perm_state_out, dout, dout_valid, dout_last, busy, done
    );
endinterface

// File: rtl/shake_squeeze.sv
// SHAKE squeeze stage: streams rate lanes of the permuted state and asks for
// another permutation when a request spans more than one rate block.
module shake_squeeze
    import keccak_pkg::*;
#(
    parameter int RATE_LANES = RATE128_LANES,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    shake_squeeze_if.slave    bus
);

    localparam int IDX_W = $clog2(RATE_LANES);

    sq_state_e            r_state;
    logic [STATE_W-1:0]   r_buf;
    logic [IDX_W-1:0]     r_idx;
    logic [LEN_W-1:0]     r_rem;
    logic [LANE_W-1:0]    r_dout;
    logic                 r_dout_valid;
    logic                 r_dout_last;
    logic                 r_perm_req;
    logic                 r_done;
    logic                 r_busy;

    sq_state_e            w_state_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [LEN_W-1:0]     w_rem_nxt;
    logic [LANE_W-1:0]    w_dout_nxt;
    logic                 w_valid_nxt;
    logic                 w_last_nxt;
    logic                 w_req_nxt;
    logic                 w_done_nxt;
    logic                 w_buf_load;
    logic                 w_hs;

    assign w_hs = r_dout_valid & bus.dout_ready;

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_rem_nxt   = r_rem;
        w_dout_nxt  = {LANE_W{1'b0}};
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_req_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        w_buf_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && (bus.out_len != {LEN_W{1'b0}})) begin
                    w_state_nxt = WAIT_PERM;
                    w_rem_nxt   = bus.out_len;
                    w_idx_nxt   = {IDX_W{1'b0}};
                end else if (bus.start) begin
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_PERM: begin
                if (bus.perm_done) begin
                    w_buf_load  = 1'b1;
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_state_nxt = STREAM;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = (r_rem == LEN_W'(1));
                    w_dout_nxt  = get_lane(bus.perm_state_in, 0, RATE_LANES);
                end else begin
                    w_state_nxt = WAIT_PERM;
                end
            end
            STREAM: begin
                if (w_hs) begin
                    w_rem_nxt = r_rem - LEN_W'(1);
                    w_idx_nxt = r_idx + IDX_W'(1);
                    // Final word wins over block end: no spare permutation.
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end else if (r_idx == IDX_W'(RATE_LANES - 1)) begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_last_nxt  = (r_rem == LEN_W'(2));
                        w_dout_nxt  = get_lane(r_buf, int'(r_idx) + 1, RATE_LANES);
                    end
                end else begin
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = r_dout_last;
                    w_dout_nxt  = r_dout;
                end
            end
            REQ:     w_state_nxt = WAIT_PERM;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_buf        <= {STATE_W{1'b0}};
            r_idx        <= {IDX_W{1'b0}};
            r_rem        <= {LEN_W{1'b0}};
            r_dout       <= {LANE_W{1'b0}};
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_perm_req   <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_load ? bus.perm_state_in : r_buf;
            r_idx        <= w_idx_nxt;
            r_rem        <= w_rem_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_valid_nxt;
            r_dout_last  <= w_last_nxt;
            r_perm_req   <= w_req_nxt;
            r_done       <= w_done_nxt;
            r_busy       <= (w_state_nxt != IDLE);
        end
    end

    assign bus.perm_req       = r_perm_req;
    assign bus.perm_state_out = r_buf;
    assign bus.dout           = r_dout;
    assign bus.dout_valid     = r_dout_valid;
    assign bus.dout_last      = r_dout_last;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;

endmodule

// File: tb/tb_shake_squeeze.sv
// Directed bench for shake_squeeze: single block, multi-block, backpressure,
// exact-block, zero-length and mid-stream reset scenarios.
module tb_shake_squeeze;
    import keccak_pkg::*;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   req_cnt;
    int   done_cnt;
    int   req_base;
    int   done_base;

    logic [STATE_W-1:0] st_a, st_b, st_c, st_d, st_e, st_f, st_h;

    shake_squeeze_if #(.LEN_W(16)) sif ();

    shake_squeeze #(.RATE_LANES(21), .LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sif.perm_req) req_cnt++;
        if (sif.done) done_cnt++;
    end

    function automatic logic [STATE_W-1:0] make_state(input logic [31:0] seed);
        logic [STATE_W-1:0] s;
        for (int i = 0; i < NUM_LANES; i++) s[64*i +: 64] = {seed, 24'h0, 8'(i)};
        return s;
    endfunction

    function automatic logic [63:0] lane(input logic [STATE_W-1:0] s, input int k);
        return s[64*k +: 64];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [STATE_W-1:0] obs,
                             input logic [STATE_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed lane0 %h expected lane0 %h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    initial begin
        n_assert = 0; n_fail = 0; req_cnt = 0; done_cnt = 0;
        rst = 1'b1;
        sif.start = 1'b0; sif.out_len = 16'd0; sif.perm_done = 1'b0;
        sif.perm_state_in = {STATE_W{1'b0}}; sif.dout_ready = 1'b0;
        st_a = make_state(32'hA0A0_0001);
        st_a[63:0]    = 64'h7D828FE8A42B9C7F;
        st_a[127:64]  = 64'h3E85057650456061;
        st_b = make_state(32'hB0B0_0002);
        st_c = make_state(32'hC0C0_0003);
        st_d = make_state(32'hD0D0_0004);
        st_e = make_state(32'hE0E0_0005);
        st_f = make_state(32'hF0F0_0006);
        st_h = make_state(32'h1234_0008);
        step(); step();
        rst = 1'b0;

        // reset state
        chk("rst_dout", sif.dout, 64'd0);
        chk("rst_valid", 64'(sif.dout_valid), 64'd0);
        chk("rst_last", 64'(sif.dout_last), 64'd0);
        chk("rst_req", 64'(sif.perm_req), 64'd0);
        chk("rst_busy", 64'(sif.busy), 64'd0);
        chk("rst_done", 64'(sif.done), 64'd0);
        chk_state("rst_pso", sif.perm_state_out, {STATE_W{1'b0}});

        // 1: SHAKE128("") first two words
        req_base = req_cnt;
        sif.start = 1'b1; sif.out_len = 16'd2; sif.dout_ready = 1'b1;
        step();
        sif.start = 1'b0;
        chk("t1_busy", 64'(sif.busy), 64'd1);
        chk("t1_wait_valid", 64'(sif.dout_valid), 64'd0);
        step();
        sif.perm_done = 1'b1; sif.perm_state_in = st_a;
        step();
        sif.perm_done = 1'b0;
        chk("t1_w0", sif.dout, 64'h7D828FE8A42B9C7F);
        chk("t1_w0_valid", 64'(sif.dout_valid), 64'd1);
        chk("t1_w0_last", 64'(sif.dout_last), 64'd0);
        step();
        chk("t1_w1", sif.dout, 64'h3E85057650456061);
        chk("t1_w1_last", 64'(sif.dout_last), 64'd1);
        step();
        chk("t1_done", 64'(sif.done), 64'd1);
        chk("t1_done_valid", 64'(sif.dout_valid), 64'd0);
        step();
        chk("t1_done_off", 64'(sif.done), 64'd0);
        chk("t1_idle", 64'(sif.busy), 64'd0);
        chk("t1_noreq", 64'(req_cnt - req_base), 64'd0);

        // 2: 22 words across two blocks
        req_base = req_cnt;
        sif.start = 1'b1; sif.out_len = 16'd22;
        step();
        sif.start = 1'b0; sif.perm_done = 1'b1; sif.perm_state_in = st_b;
        step();
        sif.perm_done = 1'b0;
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("t2_w%0d", k), sif.dout, lane(st_b, k));
            chk($sformatf("t2_v%0d", k), 64'(sif.dout_valid), 64'd1);
            chk($sformatf("t2_l%0d", k), 64'(sif.dout_last), 64'd0);
            step();
        end
        chk("t2_req", 64'(sif.perm_req), 64'd1);
        chk("t2_req_valid", 64'(sif.dout_valid), 64'd0);
        chk_state("t2_pso", sif.perm_state_out, st_b);
        step();
        chk("t2_req_pulse", 64'(sif.perm_req), 64'd0);
        chk("t2_wait_busy", 64'(sif.busy), 64'd1);
        sif.perm_done = 1'b1; sif.perm_state_in = st_c;
        step();
        sif.perm_done = 1'b0;
        chk("t2_w21", sif.dout, lane(st_c, 0));
        chk("t2_w21_last", 64'(sif.dout_last), 64'd1);
        step();
        chk("t2_done", 64'(sif.done), 64'd1);
        step();
        chk("t2_reqcnt", 64'(req_cnt - req_base), 64'd1);

        // 3: backpressure mid-block
        sif.start = 1'b1; sif.out_len = 16'd4;
        step();
        sif.start = 1'b0; sif.perm_done = 1'b1; sif.perm_state_in = st_d;
        step();
        sif.perm_done = 1'b0;
        chk("t3_w0", sif.dout, lane(st_d, 0));
        step();
        sif.dout_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_hold_d%0d", k), sif.dout, lane(st_d, 1));
            chk($sformatf("t3_hold_v%0d", k), 64'(sif.dout_valid), 64'd1);
            chk($sformatf("t3_hold_l%0d", k), 64'(sif.dout_last), 64'd0);
            step();
        end
        chk("t3_hold_end", sif.dout, lane(st_d, 1));
        sif.dout_ready = 1'b1;
        step();
        chk("t3_w2", sif.dout, lane(st_d, 2));
        step();
        chk("t3_w3", sif.dout, lane(st_d, 3));
        chk("t3_w3_last", 64'(sif.dout_last), 64'd1);
        step();
        chk("t3_done", 64'(sif.done), 64'd1);
        step();

        // 4: exactly one block, no extra permutation
        req_base = req_cnt;
        sif.start = 1'b1; sif.out_len = 16'd21;
        step();
        sif.start = 1'b0; sif.perm_done = 1'b1; sif.perm_state_in = st_e;
        step();
        sif.perm_done = 1'b0;
        for (int k = 0; k < 21; k++) begin
            chk($sformatf("t4_w%0d", k), sif.dout, lane(st_e, k));
            chk($sformatf("t4_l%0d", k), 64'(sif.dout_last), (k == 20) ? 64'd1 : 64'd0);
            step();
        end
        chk("t4_done", 64'(sif.done), 64'd1);
        chk("t4_req", 64'(sif.perm_req), 64'd0);
        step();
        chk("t4_noreq", 64'(req_cnt - req_base), 64'd0);

        // 5: zero-length request
        done_base = done_cnt;
        sif.start = 1'b1; sif.out_len = 16'd0;
        step();
        sif.start = 1'b0;
        chk("t5_done", 64'(sif.done), 64'd1);
        chk("t5_busy", 64'(sif.busy), 64'd0);
        chk("t5_valid", 64'(sif.dout_valid), 64'd0);
        step();
        chk("t5_done_off", 64'(sif.done), 64'd0);
        chk("t5_donecnt", 64'(done_cnt - done_base), 64'd1);

        // 6: reset during streaming at word 5
        sif.start = 1'b1; sif.out_len = 16'd30;
        step();
        sif.start = 1'b0; sif.perm_done = 1'b1; sif.perm_state_in = st_f;
        step();
        sif.perm_done = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("t6_w5", sif.dout, lane(st_f, 5));
        rst = 1'b1; sif.perm_done = 1'b1; sif.perm_state_in = st_h;
        step();
        rst = 1'b0; sif.perm_done = 1'b0;
        chk("t6_dout", sif.dout, 64'd0);
        chk("t6_valid", 64'(sif.dout_valid), 64'd0);
        chk("t6_busy", 64'(sif.busy), 64'd0);
        chk_state("t6_pso", sif.perm_state_out, {STATE_W{1'b0}});
        sif.perm_done = 1'b1; sif.perm_state_in = st_c;
        step();
        sif.perm_done = 1'b0;
        chk("t6_stray_valid", 64'(sif.dout_valid), 64'd0);
        chk("t6_stray_busy", 64'(sif.busy), 64'd0);
        chk_state("t6_stray_pso", sif.perm_state_out, {STATE_W{1'b0}});
        sif.start = 1'b1; sif.out_len = 16'd1;
        step();
        sif.start = 1'b0; sif.perm_done = 1'b1; sif.perm_state_in = st_h;
        step();
        sif.perm_done = 1'b0;
        chk("t6_w0", sif.dout, lane(st_h, 0));
        chk("t6_w0_last", 64'(sif.dout_last), 64'd1);
        step();
        chk("t6_done", 64'(sif.done), 64'd1);
        step();
        chk("t6_idle", 64'(sif.busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
